// File: rtl/croc_obi_reg_bridge.sv
// OBI subordinate to regbus bridge: one outstanding access, bounded regbus wait,
// single-cycle OBI response. Carries the default bus types it is built against.

package croc_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  aid;
  } sbr_obi_a_chan_t;

  typedef struct packed {
    logic            req;
    sbr_obi_a_chan_t a;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  rid;
    logic        err;
    logic        r_optional;
  } sbr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    sbr_obi_r_chan_t r;
  } sbr_obi_rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

module croc_obi_reg_bridge #(
  parameter type         obi_req_t     = croc_pkg::sbr_obi_req_t,
  parameter type         obi_rsp_t     = croc_pkg::sbr_obi_rsp_t,
  parameter type         reg_req_t     = croc_pkg::reg_req_t,
  parameter type         reg_rsp_t     = croc_pkg::reg_rsp_t,
  parameter int unsigned TimeoutCycles = 256,
  parameter logic [31:0] ErrData       = 32'hBADC_AB1E
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  obi_req_t obi_req_i,
  output obi_rsp_t obi_rsp_o,
  output reg_req_t reg_req_o,
  input  reg_rsp_t reg_rsp_i
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  localparam logic [15:0] CntLast = 16'(TimeoutCycles - 1);

  state_e state_q, state_d;

  logic [$bits(obi_req_i.a.addr)-1:0]  addr_q, addr_d;
  logic                                we_q, we_d;
  logic [$bits(obi_req_i.a.be)-1:0]    be_q, be_d;
  logic [$bits(obi_req_i.a.wdata)-1:0] wdata_q, wdata_d;
  logic [$bits(obi_req_i.a.aid)-1:0]   aid_q, aid_d;
  logic [31:0]                         rdata_q, rdata_d;
  logic                                err_q, err_d;
  logic [15:0]                         cnt_q, cnt_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    aid_d     = aid_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    obi_rsp_o = '0;
    reg_req_o = '0;

    unique case (state_q)
      IDLE: begin
        obi_rsp_o.gnt = obi_req_i.req;
        if (obi_req_i.req) begin
          addr_d  = obi_req_i.a.addr;
          we_d    = obi_req_i.a.we;
          be_d    = obi_req_i.a.be;
          wdata_d = obi_req_i.a.wdata;
          aid_d   = obi_req_i.a.aid;
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        reg_req_o.valid = 1'b1;
        reg_req_o.addr  = addr_q;
        reg_req_o.write = we_q;
        reg_req_o.wdata = wdata_q;
        reg_req_o.wstrb = we_q ? be_q : '0;
        // A ready arriving on the last allowed cycle wins over the timeout.
        if (reg_rsp_i.ready) begin
          rdata_d = we_q ? 32'h0 : reg_rsp_i.rdata;
          err_d   = reg_rsp_i.error;
          state_d = RESP;
        end else if (cnt_q == CntLast) begin
          rdata_d = ErrData;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      RESP: begin
        obi_rsp_o.rvalid  = 1'b1;
        obi_rsp_o.r.rdata = rdata_q;
        obi_rsp_o.r.rid   = aid_q;
        obi_rsp_o.r.err   = err_q;
        state_d           = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Outputs are forced quiet for the whole reset window, not just after the edge.
    if (rst_i) begin
      obi_rsp_o = '0;
      reg_req_o = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      aid_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      aid_q   <= aid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_croc_obi_reg_bridge.sv
// Scoreboard bench for croc_obi_reg_bridge: three instances (timeouts 6, 4 and 1),
// directed stimulus pushes expectations, per-instance monitors pop and compare.

module tb_croc_obi_reg_bridge;
  import croc_pkg::*;

  localparam int NDUT = 3;
  localparam logic [31:0] ERR = 32'hBADC_AB1E;

  function automatic int unsigned to_of(input int i);
    return (i == 0) ? 6 : ((i == 1) ? 4 : 1);
  endfunction

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic [1:0]  rid;
    logic        err;
    int          cyc;
  } exp_rsp_t;

  typedef struct {
    int          inst;
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          nvalid;
  } exp_reg_t;

  logic         clk = 1'b0;
  logic         rst;
  sbr_obi_req_t obi_req [NDUT];
  sbr_obi_rsp_t obi_rsp [NDUT];
  reg_req_t     reg_req [NDUT];
  reg_rsp_t     reg_rsp [NDUT];

  int cyc = 0;
  int n_pass = 0;
  int n_checks = 0;
  int gnt_cnt [NDUT] = '{default: 0};

  int          rsp_wait  [NDUT] = '{default: 0};
  bit          rsp_never [NDUT] = '{default: 1'b0};
  logic [31:0] rsp_rdata [NDUT] = '{default: 32'h0};
  bit          rsp_err   [NDUT] = '{default: 1'b0};

  exp_rsp_t rsp_q[$];
  exp_reg_t reg_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    croc_obi_reg_bridge #(
      .TimeoutCycles(to_of(gi))
    ) u_dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .obi_req_i(obi_req[gi]),
      .obi_rsp_o(obi_rsp[gi]),
      .reg_req_o(reg_req[gi]),
      .reg_rsp_i(reg_rsp[gi])
    );

    // Regbus subordinate: ready after rsp_wait stalled cycles, or never.
    initial begin : responder
      int w;
      w = 0;
      reg_rsp[gi] = '0;
      forever begin
        @(posedge clk);
        #1;
        reg_rsp[gi] = '0;
        if (reg_req[gi].valid) begin
          if (!rsp_never[gi] && w == rsp_wait[gi]) begin
            reg_rsp[gi].ready = 1'b1;
            reg_rsp[gi].rdata = rsp_rdata[gi];
            reg_rsp[gi].error = rsp_err[gi];
          end
          w++;
        end else begin
          w = 0;
        end
      end
    end

    initial begin : monitor
      int       run;
      bit       found_reg;
      bit       found;
      reg_req_t first;
      exp_reg_t er;
      exp_rsp_t ep;
      run = 0;
      found_reg = 1'b0;
      forever begin
        @(negedge clk);
        if (obi_rsp[gi].gnt) gnt_cnt[gi]++;

        if (obi_rsp[gi].rvalid) begin
          found = 1'b0;
          for (int k = 0; k < rsp_q.size(); k++) begin
            if (rsp_q[k].inst == gi) begin
              ep = rsp_q[k];
              rsp_q.delete(k);
              found = 1'b1;
              break;
            end
          end
          if (!found) begin
            check("unexpected_rvalid", obi_rsp[gi].rvalid, 0);
          end else begin
            check("rdata", obi_rsp[gi].r.rdata, ep.rdata);
            check("rid", obi_rsp[gi].r.rid, ep.rid);
            check("err", obi_rsp[gi].r.err, ep.err);
            check("rvalid_cycle", cyc, ep.cyc);
          end
        end else begin
          check("rsp_idle_zero", obi_rsp[gi].r, '0);
        end

        if (reg_req[gi].valid) begin
          if (run == 0) begin
            found_reg = 1'b0;
            for (int k = 0; k < reg_q.size(); k++) begin
              if (reg_q[k].inst == gi) begin
                er = reg_q[k];
                reg_q.delete(k);
                found_reg = 1'b1;
                break;
              end
            end
            if (!found_reg) begin
              check("unexpected_reg_valid", reg_req[gi].valid, 0);
            end else begin
              check("reg_addr", reg_req[gi].addr, er.addr);
              check("reg_write", reg_req[gi].write, er.write);
              check("reg_wdata", reg_req[gi].wdata, er.wdata);
              check("reg_wstrb", reg_req[gi].wstrb, er.wstrb);
            end
            first = reg_req[gi];
          end else begin
            check("reg_stable", reg_req[gi], first);
          end
          run++;
        end else begin
          if (run > 0 && found_reg) check("valid_cycles", run, er.nvalid);
          run = 0;
          check("reg_idle_zero", reg_req[gi], '0);
        end
      end
    end
  end

  task automatic wait_gnt(input int i, output int g, output int lat);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (obi_rsp[i].gnt) begin
        g   = cyc;
        lat = n;
        return;
      end
    end
    g   = cyc;
    lat = 20;
    check("gnt_wait", obi_rsp[i].gnt, 1);
  endtask

  task automatic drain();
    for (int n = 0; n < 100; n++) begin
      if (rsp_q.size() == 0 && reg_q.size() == 0) return;
      @(negedge clk);
    end
    check("drain", rsp_q.size() + reg_q.size(), 0);
    rsp_q.delete();
    reg_q.delete();
  endtask

  task automatic set_resp(input int i, input int wt, input bit never, input logic [31:0] rd, input bit er);
    rsp_wait[i]  = wt;
    rsp_never[i] = never;
    rsp_rdata[i] = rd;
    rsp_err[i]   = er;
  endtask

  task automatic drive_req(input int i, input logic [31:0] addr, input logic we, input logic [3:0] be,
                           input logic [31:0] wdata, input logic [1:0] aid);
    obi_req[i].req     = 1'b1;
    obi_req[i].a.addr  = addr;
    obi_req[i].a.we    = we;
    obi_req[i].a.be    = be;
    obi_req[i].a.wdata = wdata;
    obi_req[i].a.aid   = aid;
  endtask

  task automatic push_exp(input int i, input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                          input logic [1:0] aid, input logic [31:0] x_rdata, input logic x_err,
                          input logic [3:0] x_wstrb, input int x_nvalid, input int x_cyc);
    reg_q.push_back('{inst: i, addr: addr, write: we, wdata: wdata, wstrb: x_wstrb, nvalid: x_nvalid});
    rsp_q.push_back('{inst: i, rdata: x_rdata, rid: aid, err: x_err, cyc: x_cyc});
  endtask

  // One transaction; expected values are hand-computed by the caller.
  task automatic issue(input int i, input logic [31:0] addr, input logic we, input logic [3:0] be,
                       input logic [31:0] wdata, input logic [1:0] aid,
                       input int wt, input bit never, input logic [31:0] rd, input bit er,
                       input logic [31:0] x_rdata, input logic x_err, input logic [3:0] x_wstrb,
                       input int x_nvalid, input int x_lat);
    int g, lat;
    drain();
    set_resp(i, wt, never, rd, er);
    @(posedge clk);
    #1;
    drive_req(i, addr, we, be, wdata, aid);
    wait_gnt(i, g, lat);
    check("gnt_latency", lat, 0);
    push_exp(i, addr, we, wdata, aid, x_rdata, x_err, x_wstrb, x_nvalid, g + x_lat);
    @(posedge clk);
    #1;
    obi_req[i] = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g1, g2, lat, gc0;

    // Reset: outputs quiet even with req high.
    rst = 1'b1;
    for (int i = 0; i < NDUT; i++) obi_req[i] = '0;
    drive_req(0, 32'h0300_2000, 1'b1, 4'hF, 32'hFFFF_FFFF, 2'd1);
    repeat (3) begin
      @(negedge clk);
      check("rst_gnt", obi_rsp[0].gnt, 0);
      check("rst_rsp_zero", obi_rsp[0], '0);
      check("rst_reg_zero", reg_req[0], '0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    obi_req[0] = '0;

    // Read, zero wait.
    issue(0, 32'h0300_2004, 1'b0, 4'hF, 32'hDEAD_BEEF, 2'd3, 0, 1'b0, 32'h1234_5678, 1'b0,
          32'h1234_5678, 1'b0, 4'b0000, 1, 2);
    // Write, five wait states; ready lands on the last counter value (timeout 6).
    issue(0, 32'h0300_2008, 1'b1, 4'b0101, 32'hA5A5_A5A5, 2'd1, 5, 1'b0, 32'hFFFF_0000, 1'b0,
          32'h0, 1'b0, 4'b0101, 6, 7);
    // Read with regbus error: rdata passes through.
    issue(0, 32'h0300_200C, 1'b0, 4'hF, 32'h0, 2'd2, 1, 1'b0, 32'hCAFE_F00D, 1'b1,
          32'hCAFE_F00D, 1'b1, 4'b0000, 2, 3);
    // Write with regbus error: rdata still zero.
    issue(0, 32'h0300_2010, 1'b1, 4'b1111, 32'h0000_0001, 2'd0, 0, 1'b0, 32'h5555_5555, 1'b1,
          32'h0, 1'b1, 4'b1111, 1, 2);
    // Timeout with TimeoutCycles=4.
    issue(1, 32'h0300_2014, 1'b0, 4'hF, 32'h0, 2'd2, 0, 1'b1, 32'h0, 1'b0,
          ERR, 1'b1, 4'b0000, 4, 5);
    // Timeout with TimeoutCycles=1.
    issue(2, 32'h0300_2018, 1'b0, 4'hF, 32'h0, 2'd1, 0, 1'b1, 32'h0, 1'b0,
          ERR, 1'b1, 4'b0000, 1, 2);
    // Timeout on a write with TimeoutCycles=6.
    issue(0, 32'h0300_201C, 1'b1, 4'b1000, 32'h1234_0000, 2'd3, 0, 1'b1, 32'h0, 1'b0,
          ERR, 1'b1, 4'b1000, 6, 7);

    // Back-to-back with req held; fields change during ACCESS and must not leak in.
    drain();
    set_resp(0, 0, 1'b0, 32'h0BAD_F00D, 1'b0);
    gc0 = gnt_cnt[0];
    @(posedge clk);
    #1;
    drive_req(0, 32'h0300_2020, 1'b0, 4'hF, 32'h0, 2'd1);
    wait_gnt(0, g1, lat);
    push_exp(0, 32'h0300_2020, 1'b0, 32'h0, 2'd1, 32'h0BAD_F00D, 1'b0, 4'b0000, 1, g1 + 2);
    @(posedge clk);
    #1;
    drive_req(0, 32'h0300_2024, 1'b1, 4'b0011, 32'h1111_2222, 2'd2);
    wait_gnt(0, g2, lat);
    check("b2b_gnt_spacing", g2 - g1, 3);
    push_exp(0, 32'h0300_2024, 1'b1, 32'h1111_2222, 2'd2, 32'h0, 1'b0, 4'b0011, 1, g2 + 2);
    @(posedge clk);
    #1;
    obi_req[0] = '0;
    drain();
    check("b2b_gnt_pulses", gnt_cnt[0] - gc0, 2);

    // Reset mid-access: valid seen for two cycles, then reset with req high; no rvalid follows.
    set_resp(0, 0, 1'b1, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    drive_req(0, 32'h0300_2030, 1'b0, 4'hF, 32'h0, 2'd1);
    wait_gnt(0, g1, lat);
    reg_q.push_back('{inst: 0, addr: 32'h0300_2030, write: 1'b0, wdata: 32'h0, wstrb: 4'b0000, nvalid: 2});
    @(posedge clk);
    #1;
    obi_req[0] = '0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive_req(0, 32'h0300_2040, 1'b1, 4'hF, 32'h9999_9999, 2'd2);
    repeat (2) begin
      @(negedge clk);
      check("rst_mid_gnt", obi_rsp[0].gnt, 0);
      check("rst_mid_rsp_zero", obi_rsp[0], '0);
      check("rst_mid_reg_zero", reg_req[0], '0);
      if (cyc < g1 + 4) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    obi_req[0] = '0;
    repeat (10) @(negedge clk);

    // Normal read after the aborted access.
    issue(0, 32'h0300_2034, 1'b0, 4'hF, 32'h0, 2'd0, 2, 1'b0, 32'h7777_8888, 1'b0,
          32'h7777_8888, 1'b0, 4'b0000, 3, 4);

    drain();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
